// File: rtl/ucsbece154b_icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the FSM state encoding, default geometry and address-field width helpers.
// No logic of its own; imported by the cache top and its FSM.
package ucsbece154b_icache_pkg;

    typedef enum logic [1:0] {
        icache_idle   = 2'd0,
        icache_req    = 2'd1,
        icache_refill = 2'd2
    } icache_state_t;

    localparam int unsigned ICACHE_NUM_SETS       = 8;
    localparam int unsigned ICACHE_WORDS_PER_LINE = 4;
    localparam int unsigned ICACHE_ADDR_W         = 32;

    // Word-offset field width (selects a word within a line).
    function automatic int unsigned icache_offset_w(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Index field width (selects a line).
    function automatic int unsigned icache_index_w(input int unsigned num_sets);
        return $clog2(num_sets);
    endfunction

    // Tag is whatever remains above offset, index and the two byte bits.
    function automatic int unsigned icache_tag_w(input int unsigned num_sets,
                                                 input int unsigned words_per_line);
        return ICACHE_ADDR_W - $clog2(num_sets) - $clog2(words_per_line) - 2;
    endfunction

endpackage

// File: rtl/ucsbece154b_icache_fsm.sv
// Miss-handling controller: IDLE -> REQ (one-cycle burst request) -> REFILL -> IDLE.
// Leaves IDLE the cycle after a miss; REQ lasts exactly one cycle; REFILL lasts until the last beat.
// Beats may arrive at any spacing; the controller simply waits in REFILL for each one.
module ucsbece154b_icache_fsm
    import ucsbece154b_icache_pkg::*;
#(
    parameter int unsigned WORDS_PER_LINE = ICACHE_WORDS_PER_LINE,
    localparam int unsigned CNT_W = icache_offset_w(WORDS_PER_LINE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_enable_i,
    input  logic              hit_i,
    input  logic              mem_data_ready_i,
    input  logic              last_beat_i,
    output icache_state_t     state_o,
    output logic [CNT_W-1:0]  beat_cnt_o,
    output logic              mem_read_request_o,
    output logic              busy_o
);

    icache_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State register and beat counter; reset abandons any refill in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= icache_idle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter update and the request pulse.
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        mem_read_request_o = 1'b0;
        case (state_q)
            icache_idle: begin
                if (read_enable_i && !hit_i) state_d = icache_refill == icache_refill ? icache_req : icache_idle;
            end
            icache_req: begin
                mem_read_request_o = 1'b1;
                cnt_d              = '0;
                state_d            = icache_refill;
            end
            icache_refill: begin
                if (mem_data_ready_i) begin
                    // Counter wraps back to zero on the last beat.
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat_i) state_d = icache_idle;
                end
            end
            default: state_d = icache_idle;
        endcase
    end

    assign state_o    = state_q;
    assign beat_cnt_o = cnt_q;
    assign busy_o     = (state_q != icache_idle);

endmodule

// File: rtl/ucsbece154b_icache.sv
// Direct-mapped read-only instruction cache between fetch and a word-serial memory.
// Hit latency 0 cycles (combinational); miss penalty at least 2 + WORDS_PER_LINE cycles.
// Ready_o drops on a miss and stays low until the line is refilled; fetch stalls on !Ready_o.
module ucsbece154b_icache
    import ucsbece154b_icache_pkg::*;
#(
    parameter int unsigned NUM_SETS       = ICACHE_NUM_SETS,
    parameter int unsigned WORDS_PER_LINE = ICACHE_WORDS_PER_LINE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReadEnable_i,
    input  logic [31:0] ReadAddress_i,
    output logic [31:0] Instruction_o,
    output logic        Ready_o,
    output logic        Busy_o,
    output logic        MemReadRequest_o,
    output logic [31:0] MemReadAddress_o,
    input  logic        MemDataReady_i,
    input  logic [31:0] MemDataIn_i
);

    localparam int unsigned OFF_W  = icache_offset_w(WORDS_PER_LINE);
    localparam int unsigned IDX_W  = icache_index_w(NUM_SETS);
    localparam int unsigned TAG_W  = icache_tag_w(NUM_SETS, WORDS_PER_LINE);
    localparam int unsigned LINE_W = TAG_W + IDX_W;
    localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(WORDS_PER_LINE - 1);

    // Storage arrays: data and tags are don't-care until the valid bit is set.
    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [TAG_W-1:0]    tag_d  [NUM_SETS];
    logic [31:0]         data_q [NUM_SETS][WORDS_PER_LINE];
    logic [31:0]         data_d [NUM_SETS][WORDS_PER_LINE];
    logic [LINE_W-1:0]   line_addr_q, line_addr_d;

    icache_state_t      state;
    logic [OFF_W-1:0]   beat_cnt;
    logic               hit;
    logic               last_beat;
    logic               unused_addr_bits;

    logic [OFF_W-1:0]   req_off;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;

    assign req_off  = ReadAddress_i[OFF_W+1:2];
    assign req_idx  = ReadAddress_i[OFF_W+IDX_W+1:OFF_W+2];
    assign req_tag  = ReadAddress_i[31:OFF_W+IDX_W+2];
    assign fill_idx = line_addr_q[IDX_W-1:0];
    assign fill_tag = line_addr_q[LINE_W-1:IDX_W];
    // Byte-within-word bits play no part in an instruction fetch.
    assign unused_addr_bits = ^ReadAddress_i[1:0];

    assign hit       = ReadEnable_i && (state == icache_idle) && valid_q[req_idx]
                       && (tag_q[req_idx] == req_tag);
    assign last_beat = (state == icache_refill) && MemDataReady_i && (beat_cnt == LAST_CNT);

    assign Ready_o          = hit;
    assign Instruction_o    = hit ? data_q[req_idx][req_off] : 32'd0;
    assign MemReadAddress_o = {line_addr_q, {(OFF_W+2){1'b0}}};

    ucsbece154b_icache_fsm #(
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_fsm (
        .clk                (clk),
        .reset              (reset),
        .read_enable_i      (ReadEnable_i),
        .hit_i              (hit),
        .mem_data_ready_i   (MemDataReady_i),
        .last_beat_i        (last_beat),
        .state_o            (state),
        .beat_cnt_o         (beat_cnt),
        .mem_read_request_o (MemReadRequest_o),
        .busy_o             (Busy_o)
    );

    // Miss-address latch and refill writes into the array being filled.
    always_comb begin
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        line_addr_d = line_addr_q;
        if ((state == icache_idle) && ReadEnable_i && !hit) begin
            line_addr_d = ReadAddress_i[31:OFF_W+2];
        end
        if ((state == icache_refill) && MemDataReady_i) begin
            data_d[fill_idx][beat_cnt] = MemDataIn_i;
            if (last_beat) begin
                tag_d[fill_idx]   = fill_tag;
                valid_d[fill_idx] = 1'b1;
            end
        end
    end

    // Valid bits and the burst address reset; a partial line never becomes valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= '0;
            line_addr_q <= '0;
        end else begin
            valid_q     <= valid_d;
            line_addr_q <= line_addr_d;
        end
    end

    // Tag and data arrays carry no reset; they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_ucsbece154b_icache.sv
// Directed bench for the instruction cache: reset, cold miss, hits, conflict, spaced beats,
// reset during refill and disabled reads. Inputs change on the falling edge; outputs are
// sampled 1 ns later so combinational hit results settle well before the rising edge.
module tb_ucsbece154b_icache;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReadEnable_i;
    logic [31:0] ReadAddress_i;
    logic [31:0] Instruction_o;
    logic        Ready_o;
    logic        Busy_o;
    logic        MemReadRequest_o;
    logic [31:0] MemReadAddress_o;
    logic        MemDataReady_i;
    logic [31:0] MemDataIn_i;

    int n_cmp = 0;
    int n_bad = 0;
    int req_cnt = 0;

    ucsbece154b_icache #(.NUM_SETS(8), .WORDS_PER_LINE(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .ReadEnable_i     (ReadEnable_i),
        .ReadAddress_i    (ReadAddress_i),
        .Instruction_o    (Instruction_o),
        .Ready_o          (Ready_o),
        .Busy_o           (Busy_o),
        .MemReadRequest_o (MemReadRequest_o),
        .MemReadAddress_o (MemReadAddress_o),
        .MemDataReady_i   (MemDataReady_i),
        .MemDataIn_i      (MemDataIn_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (MemReadRequest_o === 1'b1) req_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset;
        reset = 1'b1; ReadEnable_i = 1'b0; ReadAddress_i = 32'h0;
        MemDataReady_i = 1'b0; MemDataIn_i = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0; #1;
        n_cmp++; if (Ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%0b exp=0", Ready_o); end
        n_cmp++; if (Busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0b exp=0", Busy_o); end
        n_cmp++; if (MemReadRequest_o !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%0b exp=0", MemReadRequest_o); end
        n_cmp++; if (MemReadAddress_o !== 32'h0) begin n_bad++; $display("FAIL reset_maddr got=%h exp=0", MemReadAddress_o); end
        n_cmp++; if (Instruction_o !== 32'h0) begin n_bad++; $display("FAIL reset_instr got=%h exp=0", Instruction_o); end
    endtask

    // Drives one full miss: detect, request pulse, four beats with `gap` idle cycles before each.
    task automatic run_refill(input logic [31:0] addr, input logic [3:0][31:0] beats,
                              input int gap, input string name);
        int          req_before;
        logic [31:0] exp_line;
        req_before = req_cnt;
        exp_line   = {addr[31:4], 4'b0000};
        @(negedge clk); ReadEnable_i = 1'b1; ReadAddress_i = addr; MemDataReady_i = 1'b0; #1;
        n_cmp++; if (Ready_o !== 1'b0) begin n_bad++; $display("FAIL %s_miss_ready got=%0b exp=0", name, Ready_o); end
        n_cmp++; if (Busy_o !== 1'b0) begin n_bad++; $display("FAIL %s_miss_busy got=%0b exp=0", name, Busy_o); end
        // Address changes during the miss must be ignored.
        @(negedge clk); ReadAddress_i = addr ^ 32'h40; #1;
        n_cmp++; if (MemReadRequest_o !== 1'b1) begin n_bad++; $display("FAIL %s_req_pulse got=%0b exp=1", name, MemReadRequest_o); end
        n_cmp++; if (MemReadAddress_o !== exp_line) begin n_bad++; $display("FAIL %s_req_addr got=%h exp=%h", name, MemReadAddress_o, exp_line); end
        n_cmp++; if (Ready_o !== 1'b0 || Busy_o !== 1'b1) begin n_bad++; $display("FAIL %s_req_state ready=%0b busy=%0b exp ready=0 busy=1", name, Ready_o, Busy_o); end
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk); MemDataReady_i = 1'b0; #1;
                n_cmp++; if (Ready_o !== 1'b0 || Busy_o !== 1'b1) begin n_bad++; $display("FAIL %s_gap%0d_%0d ready=%0b busy=%0b exp ready=0 busy=1", name, b, g, Ready_o, Busy_o); end
            end
            @(negedge clk); MemDataReady_i = 1'b1; MemDataIn_i = beats[b]; #1;
            n_cmp++; if (Ready_o !== 1'b0 || Busy_o !== 1'b1 || MemReadRequest_o !== 1'b0) begin n_bad++; $display("FAIL %s_beat%0d ready=%0b busy=%0b req=%0b exp 0/1/0", name, b, Ready_o, Busy_o, MemReadRequest_o); end
            n_cmp++; if (MemReadAddress_o !== exp_line) begin n_bad++; $display("FAIL %s_beat%0d_addr got=%h exp=%h", name, b, MemReadAddress_o, exp_line); end
        end
        @(negedge clk); MemDataReady_i = 1'b0; ReadAddress_i = addr; #1;
        n_cmp++; if (Ready_o !== 1'b1) begin n_bad++; $display("FAIL %s_done_ready got=%0b exp=1", name, Ready_o); end
        n_cmp++; if (Instruction_o !== beats[addr[3:2]]) begin n_bad++; $display("FAIL %s_done_instr got=%h exp=%h", name, Instruction_o, beats[addr[3:2]]); end
        n_cmp++; if (Busy_o !== 1'b0) begin n_bad++; $display("FAIL %s_done_busy got=%0b exp=0", name, Busy_o); end
        n_cmp++; if (req_cnt !== req_before + 1) begin n_bad++; $display("FAIL %s_req_count got=%0d exp=%0d", name, req_cnt, req_before + 1); end
    endtask

    task automatic test_cold_miss;
        run_refill(32'h0000_0000, {32'h44, 32'h33, 32'h22, 32'h11}, 0, "cold");
        n_cmp++; if (req_cnt !== 1) begin n_bad++; $display("FAIL cold_total_reqs got=%0d exp=1", req_cnt); end
    endtask

    task automatic test_hits;
        logic [31:0] addrs [3];
        logic [31:0] exps  [3];
        int          req_before;
        addrs = '{32'h4, 32'h8, 32'hC};
        exps  = '{32'h22, 32'h33, 32'h44};
        req_before = req_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); ReadEnable_i = 1'b1; ReadAddress_i = addrs[i]; #1;
            n_cmp++; if (Ready_o !== 1'b1) begin n_bad++; $display("FAIL hit_%h_ready got=%0b exp=1", addrs[i], Ready_o); end
            n_cmp++; if (Instruction_o !== exps[i]) begin n_bad++; $display("FAIL hit_%h_instr got=%h exp=%h", addrs[i], Instruction_o, exps[i]); end
            n_cmp++; if (Busy_o !== 1'b0 || MemReadRequest_o !== 1'b0) begin n_bad++; $display("FAIL hit_%h_idle busy=%0b req=%0b exp 0/0", addrs[i], Busy_o, MemReadRequest_o); end
        end
        @(negedge clk); ReadEnable_i = 1'b0;
        n_cmp++; if (req_cnt !== req_before) begin n_bad++; $display("FAIL hit_no_request got=%0d exp=%0d", req_cnt, req_before); end
    endtask

    // 0x80 shares index 0 with 0x0; refilling it evicts the first line, then 0x0 refills
    // again with beats spaced three idle cycles apart.
    task automatic test_conflict_and_spacing;
        run_refill(32'h0000_0080, {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 0, "conflict");
        run_refill(32'h0000_0008, {32'h88, 32'h77, 32'h66, 32'h55}, 3, "spaced");
    endtask

    task automatic test_reset_mid_refill;
        @(negedge clk); ReadEnable_i = 1'b1; ReadAddress_i = 32'h20; MemDataReady_i = 1'b0; #1;
        n_cmp++; if (Ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_miss got=%0b exp=0", Ready_o); end
        @(negedge clk); ReadEnable_i = 1'b0; #1;
        n_cmp++; if (MemReadRequest_o !== 1'b1) begin n_bad++; $display("FAIL rst_mid_req got=%0b exp=1", MemReadRequest_o); end
        @(negedge clk); MemDataReady_i = 1'b1; MemDataIn_i = 32'hAA;
        @(negedge clk); MemDataIn_i = 32'hBB;
        // Reset arrives together with a stray beat and a fetch; reset must win.
        @(negedge clk); reset = 1'b1; MemDataIn_i = 32'hCC; ReadEnable_i = 1'b1; ReadAddress_i = 32'h0; #1;
        n_cmp++; if (Busy_o !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy_before got=%0b exp=1", Busy_o); end
        @(negedge clk); reset = 1'b0; ReadEnable_i = 1'b0; MemDataIn_i = 32'hDD; #1;
        n_cmp++; if (Busy_o !== 1'b0 || MemReadRequest_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_after busy=%0b req=%0b exp 0/0", Busy_o, MemReadRequest_o); end
        @(negedge clk); MemDataIn_i = 32'hEE; #1;
        n_cmp++; if (Busy_o !== 1'b0 || Ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stray busy=%0b ready=%0b exp 0/0", Busy_o, Ready_o); end
        @(negedge clk); MemDataReady_i = 1'b0;
        // Line 0 was valid before reset; it must miss now, and so must the partial line 2.
        run_refill(32'h0000_0000, {32'hD4, 32'hD3, 32'hD2, 32'hD1}, 1, "post_rst0");
        run_refill(32'h0000_0024, {32'hE4, 32'hE3, 32'hE2, 32'hE1}, 0, "post_rst2");
    endtask

    task automatic test_read_disabled;
        int req_before;
        req_before = req_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); ReadEnable_i = 1'b0; ReadAddress_i = 32'h40; MemDataReady_i = 1'b0; #1;
            n_cmp++; if (Ready_o !== 1'b0 || Busy_o !== 1'b0 || MemReadRequest_o !== 1'b0) begin n_bad++; $display("FAIL disabled_%0d ready=%0b busy=%0b req=%0b exp 0/0/0", i, Ready_o, Busy_o, MemReadRequest_o); end
        end
        @(negedge clk);
        n_cmp++; if (req_cnt !== req_before) begin n_bad++; $display("FAIL disabled_no_request got=%0d exp=%0d", req_cnt, req_before); end
        // Disabled-hit: line 0 holds 0xD1..0xD4, but no request means no Ready.
        ReadAddress_i = 32'h4; #1;
        n_cmp++; if (Ready_o !== 1'b0) begin n_bad++; $display("FAIL disabled_cached got=%0b exp=0", Ready_o); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hits();
        test_conflict_and_spacing();
        test_reset_mid_refill();
        test_read_disabled();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
